// File: rtl/regbank_pkg.sv
// Shared definitions for the MicroUAZ8 register-bank port controller:
// default widths, command op-codes and controller state encodings.
package regbank_pkg;

  localparam int RA_W_DEF   = 3;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_FILL  = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/regbank_port_ctrl.sv
// Initiator-side controller that owns the register bank's SelR/RW/DW port and
// turns single read-pair / write / fill-all commands into bank cycles.
module regbank_port_ctrl
  import regbank_pkg::*;
#(
  parameter int RA_W   = RA_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Cmd_Valid,
  output logic                Cmd_Ready,
  input  logic [1:0]          Cmd_Op,
  input  logic [RA_W-1:0]     Cmd_SelX,
  input  logic [RA_W-1:0]     Cmd_SelY,
  input  logic [DATA_W-1:0]   Cmd_Data,
  output logic                Rsp_Valid,
  input  logic                Rsp_Ready,
  output logic [DATA_W-1:0]   Rsp_X,
  output logic [DATA_W-1:0]   Rsp_Y,
  output logic [2*RA_W-1:0]   SelR,
  output logic                RW,
  output logic [DATA_W-1:0]   DW,
  input  logic [DATA_W-1:0]   Rx,
  input  logic [DATA_W-1:0]   Ry
);

  localparam logic [RA_W-1:0] CNT_LAST = {RA_W{1'b1}};

  state_e              state_q, state_d;
  logic [RA_W-1:0]     cnt_q, cnt_d;
  logic [RA_W-1:0]     cntNext;
  logic [2*RA_W-1:0]   selR_q, selR_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   dw_q, dw_d;
  logic                rspValid_q, rspValid_d;
  logic [DATA_W-1:0]   rspX_q, rspX_d;
  logic [DATA_W-1:0]   rspY_q, rspY_d;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      selR_q     <= '0;
      rw_q       <= 1'b0;
      dw_q       <= '0;
      rspValid_q <= 1'b0;
      rspX_q     <= '0;
      rspY_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      selR_q     <= selR_d;
      rw_q       <= rw_d;
      dw_q       <= dw_d;
      rspValid_q <= rspValid_d;
      rspX_q     <= rspX_d;
      rspY_q     <= rspY_d;
    end
  end

  assign cntNext = cnt_q + 1'b1;

  // Bank-port registers are loaded one cycle ahead, so the values presented
  // while in WRITE/FILL/READ are computed on the edge that enters that cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    selR_d     = '0;
    rw_d       = 1'b0;
    dw_d       = '0;
    rspValid_d = rspValid_q;
    rspX_d     = rspX_q;
    rspY_d     = rspY_q;

    case (state_q)
      ST_IDLE: begin
        if (Cmd_Valid) begin
          case (Cmd_Op)
            OP_WRITE: begin
              state_d = ST_WRITE;
              selR_d  = {{RA_W{1'b0}}, Cmd_SelX};
              rw_d    = 1'b1;
              dw_d    = Cmd_Data;
            end
            OP_FILL: begin
              state_d = ST_FILL;
              cnt_d   = '0;
              rw_d    = 1'b1;
              dw_d    = Cmd_Data;
            end
            OP_READ: begin
              state_d = ST_READ;
              selR_d  = {Cmd_SelX, Cmd_SelY};
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
      end

      ST_FILL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d  = cntNext;
          selR_d = {{RA_W{1'b0}}, cntNext};
          rw_d   = 1'b1;
          dw_d   = dw_q;
        end
      end

      ST_READ: begin
        state_d    = ST_RESP;
        rspX_d     = Rx;
        rspY_d     = Ry;
        rspValid_d = 1'b1;
      end

      ST_RESP: begin
        if (Rsp_Ready) begin
          state_d    = ST_IDLE;
          rspValid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign Cmd_Ready = Rst && (state_q == ST_IDLE);
  assign SelR      = selR_q;
  assign RW        = rw_q;
  assign DW        = dw_q;
  assign Rsp_Valid = rspValid_q;
  assign Rsp_X     = rspX_q;
  assign Rsp_Y     = rspY_q;

endmodule
